// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
// Purpose: loader FSM state encoding, header/word geometry, instruction word type.
// Ports: none (package loader_pkg).
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    FLUSH,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - packs accepted bytes little-endian into 32-bit words
// Purpose: byte-lane counter plus shift register; emits a one-cycle word_ready
//          pulse the cycle after the 4th byte of a word is accepted.
// Ports:
//   clk        in   system clock, rising edge
//   clear      in   synchronous clear of lane counter, word and pulse
//   accept     in   strobe: data holds a byte belonging to the current word
//   data       in   8-bit byte
//   word       out  packed word, bits [7:0] = first byte
//   word_ready out  one-cycle pulse while word holds a freshly completed word
module word_assembler
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] data,
  output word_t      word,
  output logic       word_ready
);

  logic [1:0]  lane;
  logic [23:0] low;

  always_ff @(posedge clk) begin
    if (clear) begin
      lane       <= '0;
      low        <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (accept) begin
        if (lane == 2'(BYTES_PER_WORD - 1)) begin
          // low already holds bytes 2,1,0 from the top down
          word       <= {data, low};
          word_ready <= 1'b1;
          lane       <= '0;
        end else begin
          // shift right so the earliest byte ends up in the lowest lane
          low  <= {data, low[23:8]};
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte stream to instruction memory, then core release
// Purpose: reads a 2-byte little-endian word count N, then N*4 data bytes, writes
//          packed words to imem from address 0 and releases core_reset when done.
//          Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_data      byte stream in; in_ready out (transfer when valid && ready)
//   imem_we/addr/wdata    instruction memory write port, one pulse per word
//   core_reset            held high until the load completes
//   done, error           load completed / load aborted (both sticky until reset)
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_t           state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] n_words;
  logic [LEN_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;

  logic             xfer;
  logic             accept;
  logic [LEN_W-1:0] n_hdr;
  logic             last_byte;
  logic             last_word;
  word_t            word;
  logic             word_ready;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign xfer      = in_valid && in_ready;
  assign accept    = xfer && (state == DATA);
  assign n_hdr     = {in_data, len_lo};
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign last_word = (({1'b0, word_cnt} + 1'b1) == {1'b0, n_words});

  word_assembler u_word_assembler (
    .clk        (clk),
    .clear      (reset),
    .accept     (accept),
    .data       (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  assign imem_we    = word_ready;
  assign imem_wdata = word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LEN0;
      in_ready   <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len_lo     <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      imem_addr  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      // The final word is always written outside DATA, so the address only
      // advances after non-final writes and never wraps past the last word.
      if (word_ready && (state == DATA)) begin
        imem_addr <= imem_addr + 1'b1;
      end

      case (state)
        LEN0: begin
          in_ready <= 1'b1;
          if (xfer) begin
            len_lo <= in_data;
            state  <= LEN1;
          end
        end

        LEN1: begin
          if (xfer) begin
            n_words <= n_hdr;
            if (n_hdr == '0) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else if ({1'b0, n_hdr} > MAX_WORDS) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (last_byte) begin
              word_cnt <= word_cnt + 1'b1;
              if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state    <= FLUSH;
                in_ready <= 1'b0;
`endif
              end
            end
          end
        end

        FLUSH: begin
          state      <= DONE;
          done       <= 1'b1;
          core_reset <= 1'b0;
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
        end

        ERR: begin
        end

        default: begin
          // unreachable encodings park in ERR with the core held
          state    <= ERR;
          in_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader (ADDR_W=2)
module tb_program_loader;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  program_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  data_bytes[$];
  logic [31:0] exp_words[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int last_we_cyc = -1;
  int hdr_acc, last_acc, csum_acc;
  bit prev_cr = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every write, tracks core_reset release
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_we) begin
          last_we_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%0h data=%h cycle=%0d", imem_addr, imem_wdata, cyc);
          end else begin
            e = exp_q.pop_front();
            check("write_addr_data", 64'({imem_addr, imem_wdata}), 64'({e.addr, e.data}));
            check("write_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (prev_cr && !core_reset) fall_cyc = cyc;
      end
      prev_cr = core_reset;
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        acc = cyc;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted within 40 cycles", b);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error}),
          64'({1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}));
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    exp_q.delete();
    reset = 1'b0;
    fall_cyc = -1;
    idle();
  endtask

  task automatic run_load(input logic [7:0] h0, input logic [7:0] h1, input bit gap,
                          input int nsend, input bit send_cs, input logic [7:0] cs);
    int acc;
    wr_t w;
    send_byte(h0, acc);
    if (gap) idle();
    send_byte(h1, acc);
    hdr_acc = acc;
    if (gap) idle();
    for (int i = 0; i < nsend; i++) begin
      send_byte(data_bytes[i], acc);
      last_acc = acc;
      if (i % 4 == 3) begin
        w.addr = ADDR_W'(i / 4);
        w.data = exp_words[i / 4];
        w.cyc  = acc;
        exp_q.push_back(w);
      end
      if (gap) idle();
    end
    if (send_cs) begin
      send_byte(cs, acc);
      csum_acc = acc;
    end
  endtask

  task automatic finish_check(input string name, input bit exp_done, input int exp_fall);
    for (int i = 0; i < 20 && !(done || error); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_error"}, 64'(error), 64'(!exp_done));
    check({name, "_core_reset"}, 64'(core_reset), 64'(!exp_done));
    check({name, "_in_ready"}, 64'(in_ready), 64'(0));
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
    check({name, "_core_reset_fall"}, 64'(fall_cyc), 64'(exp_fall));
  endtask

  initial begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    bit cs_en = 1'b1;
`else
    bit cs_en = 1'b0;
`endif
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    // two words back-to-back
    apply_reset();
    data_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
    exp_words  = '{32'h00500513, 32'h00a00593};
    run_load(8'h02, 8'h00, 1'b0, 8, cs_en, 8'h70);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    finish_check("two_words", 1'b1, csum_acc);
`else
    finish_check("two_words", 1'b1, last_acc + 1);
    check("two_words_fall_after_last_write", 64'(fall_cyc), 64'(last_we_cyc + 1));
`endif

    // same stream with idle cycles between bytes
    apply_reset();
    run_load(8'h02, 8'h00, 1'b1, 8, cs_en, 8'h70);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    finish_check("gapped", 1'b1, csum_acc);
`else
    finish_check("gapped", 1'b1, last_acc + 1);
`endif

    // N = 0: straight to DONE, no writes, no checksum byte
    apply_reset();
    run_load(8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    finish_check("n_zero", 1'b1, hdr_acc);

    // N = 5 exceeds the 4-word memory
    apply_reset();
    run_load(8'h05, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    finish_check("overflow", 1'b0, -1);

    // N = 4 fills memory up to the last address
    apply_reset();
    data_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10};
    exp_words  = '{32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h100f0e0d};
    run_load(8'h04, 8'h00, 1'b0, 16, cs_en, 8'h10);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    finish_check("full_memory", 1'b1, csum_acc);
`else
    finish_check("full_memory", 1'b1, last_acc + 1);
`endif
    check("full_memory_last_addr", 64'(imem_addr), 64'(3));

    // reset after 6 data bytes, then a fresh 1-word load
    apply_reset();
    data_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
    exp_words  = '{32'h00500513, 32'h00a00593};
    run_load(8'h02, 8'h00, 1'b0, 6, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("mid_load_no_stray", 64'(exp_q.size()), 64'(0));
    apply_reset();
    exp_words = '{32'h00500513};
    run_load(8'h01, 8'h00, 1'b0, 4, cs_en, 8'h46);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    finish_check("after_reset", 1'b1, csum_acc);
`else
    finish_check("after_reset", 1'b1, last_acc + 1);
`endif

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // checksum good / bad
    apply_reset();
    data_bytes = '{8'h01, 8'h02, 8'h04, 8'h08};
    exp_words  = '{32'h08040201};
    run_load(8'h01, 8'h00, 1'b0, 4, 1'b1, 8'h0f);
    finish_check("csum_good", 1'b1, csum_acc);
    apply_reset();
    run_load(8'h01, 8'h00, 1'b0, 4, 1'b1, 8'h0e);
    finish_check("csum_bad", 1'b0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the single-cycle core.
- Receives a program as a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and writes them into instruction memory.
- Holds the core in reset until the load completes, then releases it. The core then fetches from word 0.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; capacity is 2**ADDR_W words.
- LEN_W, 16, width of the word-count header; fixed at 16 for a 2-byte header.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address being written.
- imem_wdata  out  32  packed instruction word.
- core_reset  out  1  reset to the core; high until the load completes.
- done  out  1  load finished successfully.
- error  out  1  load aborted.

Behaviour:
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_valid may drop at any time with no penalty.
- Reset values: state=LEN0, in_ready=0 during reset (1 from the first cycle after), imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0. Byte and word counters are cleared; the checksum accumulator is cleared. Memory contents are not touched.
- LEN0: in_ready=1. The accepted byte becomes N[7:0]. Next state is LEN1.
- LEN1: in_ready=1. The accepted byte becomes N[15:8].
  - If N==0, go to DONE.
  - If N>2**ADDR_W, go to ERR.
  - Otherwise go to DATA.
- DATA: in_ready=1. Bytes fill word bits [7:0], [15:8], [23:16], [31:24] in order.
  - On the 4th byte of a word, the next cycle has imem_we=1, imem_addr=word index, and imem_wdata=the packed word.
  - Word write latency is 1 cycle after the last byte is accepted.
  - The word index increments after each write.
  - After the final (N-th) word's 4th byte, go to FLUSH (or CSUM when the option is enabled).
  - A new byte may be accepted in the same cycle as an imem_we pulse, so a sustained rate of 1 byte/cycle is supported.
- FLUSH: in_ready=0. The final imem_we pulse occurs here. Next state is DONE.
- DONE: in_ready=0, done=1, core_reset=0. core_reset first goes low the cycle after the final imem_we pulse. DONE is held until reset.
- ERR: in_ready=0, error=1, core_reset=1, no writes. ERR is held until reset.
- Wrap-around: imem_addr never wraps, because the N bound is checked in LEN1. N==2**ADDR_W is legal and writes the last address.
- Reset mid-load: any state returns to LEN0 on the next edge. A pending imem_we is cancelled. A partial word is discarded.
- imem_we is never high outside DATA, FLUSH or CSUM.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - After the N*4 data bytes, state CSUM takes one extra byte with in_ready=1. The final word write pulses in CSUM.
  - If that byte equals the XOR of all data bytes (header excluded), go to DONE; otherwise go to ERR.
  - Resulting timing: core_reset falls one cycle after the checksum byte is accepted.
- When undefined: the CSUM state, the accumulator and the compare logic are absent. The sequence is DATA -> FLUSH -> DONE.

Decomposition:
- Package loader_pkg:
  - State enum: LEN0, LEN1, DATA, FLUSH, CSUM, DONE, ERR.
  - Constants: HDR_BYTES=2, BYTES_PER_WORD=4.
  - Word type: 32-bit instruction word.
- One sub-module, word_assembler:
  - Inputs: byte, accept strobe, clear.
  - Outputs: 32-bit word and word_ready pulse.
  - Contains the byte-lane counter and shift register.
- The loader keeps the FSM, word counter, checksum and handshake.

Test Plan:
- Load 2 words. Bytes 02 00 | 13 05 50 00 | 93 05 a0 00 sent back-to-back -> writes addr0=00500513 and addr1=00a00593, each 1 cycle after its 4th byte. core_reset falls 1 cycle after the addr1 pulse. done=1.
- Gaps: the same stream with in_valid low on alternate cycles -> identical writes and data. No write fires on idle cycles.
- N=0. Bytes 00 00 -> DONE directly after LEN1, no imem_we, core_reset=0.
- Overflow: ADDR_W=2 with header 05 00 -> error=1, in_ready=0, no writes, core_reset stays 1.
- Reset mid-load: after 6 data bytes, pulse reset -> LEN0, no stray write. A fresh 1-word load writes addr0 correctly.
- Checksum (PROGRAM_LOADER_CHECKSUM_EN): 1 word 01 02 04 08 then csum 0F -> done. Csum 0E -> error=1 and core_reset=1.
